// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state codes and the debug-module IR opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  localparam logic [4:0] IDCODE = 5'h01;
  localparam logic [4:0] DTMCS  = 5'h10;
  localparam logic [4:0] DMI    = 5'h11;
  localparam logic [4:0] BYPASS = 5'h1F;

endpackage

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state FSM, instruction register and negedge TDO stage.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                IR_LEN   = 5,
  parameter logic [IR_LEN-1:0] IR_RESET = IR_LEN'(IDCODE)
) (
  input  logic              tck_i,
  input  logic              ntrst_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic              tdo_en_o,
  input  logic              dr_tdo_i,
  output logic              capture_dr_o,
  output logic              shift_dr_o,
  output logic              update_dr_o,
  output logic [IR_LEN-1:0] ir_o,
  output logic              tlr_o,
  output logic [3:0]        state_o
);

  localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

  tap_state_e        state_p0;
  logic [IR_LEN-1:0] ir_shift_p0;
  logic [IR_LEN-1:0] ir_p0;
  logic              tdo_p1;
  logic              tdo_en_p1;

  // Posedge stage: TAP state machine
  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      state_p0 <= TLR;
    end else begin
      case (state_p0)
        TLR:      state_p0 <= tms_i ? TLR      : RTI;
        RTI:      state_p0 <= tms_i ? SEL_DR   : RTI;
        SEL_DR:   state_p0 <= tms_i ? SEL_IR   : CAP_DR;
        CAP_DR:   state_p0 <= tms_i ? EX1_DR   : SH_DR;
        SH_DR:    state_p0 <= tms_i ? EX1_DR   : SH_DR;
        EX1_DR:   state_p0 <= tms_i ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_p0 <= tms_i ? EX2_DR   : PAUSE_DR;
        EX2_DR:   state_p0 <= tms_i ? UPD_DR   : SH_DR;
        UPD_DR:   state_p0 <= tms_i ? SEL_DR   : RTI;
        SEL_IR:   state_p0 <= tms_i ? TLR      : CAP_IR;
        CAP_IR:   state_p0 <= tms_i ? EX1_IR   : SH_IR;
        SH_IR:    state_p0 <= tms_i ? EX1_IR   : SH_IR;
        EX1_IR:   state_p0 <= tms_i ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_p0 <= tms_i ? EX2_IR   : PAUSE_IR;
        EX2_IR:   state_p0 <= tms_i ? UPD_IR   : SH_IR;
        UPD_IR:   state_p0 <= tms_i ? SEL_DR   : RTI;
        default:  state_p0 <= TLR;
      endcase
    end
  end

  // Posedge stage: IR shift register and the held instruction
  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      ir_shift_p0 <= '0;
      ir_p0       <= IR_RESET;
    end else begin
      case (state_p0)
        CAP_IR:  ir_shift_p0 <= IR_CAPTURE;
        SH_IR:   ir_shift_p0 <= {tdi_i, ir_shift_p0[IR_LEN-1:1]};
        default: ir_shift_p0 <= ir_shift_p0;
      endcase
      if (state_p0 == TLR) begin
        ir_p0 <= IR_RESET;
      end else if (state_p0 == UPD_IR) begin
        ir_p0 <= ir_shift_p0;
      end
    end
  end

  // Negedge stage: TDO launched half a cycle after the shift, as the standard requires
  always_ff @(negedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      tdo_p1    <= 1'b0;
      tdo_en_p1 <= 1'b0;
    end else begin
      tdo_en_p1 <= (state_p0 == SH_IR) || (state_p0 == SH_DR);
      case (state_p0)
        SH_IR:   tdo_p1 <= ir_shift_p0[0];
        SH_DR:   tdo_p1 <= dr_tdo_i;
        default: tdo_p1 <= 1'b0;
      endcase
    end
  end

  // Decodes come straight off the state register so they cannot glitch
  assign capture_dr_o = (state_p0 == CAP_DR);
  assign shift_dr_o   = (state_p0 == SH_DR);
  assign update_dr_o  = (state_p0 == UPD_DR);
  assign tlr_o        = (state_p0 == TLR);
  assign state_o      = state_p0;
  assign ir_o         = ir_p0;
  assign tdo_o        = tdo_p1;
  assign tdo_en_o     = tdo_en_p1;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scans plus random TMS/TDI against a table-driven TAP model.
module tb_jtag_tap_ctrl;

  logic       tck = 1'b0;
  logic       ntrst;
  logic       tms;
  logic       tdi;
  logic       dr_tdo;
  logic       tdo_o;
  logic       tdo_en_o;
  logic       capture_dr_o;
  logic       shift_dr_o;
  logic       update_dr_o;
  logic [4:0] ir_o;
  logic       tlr_o;
  logic [3:0] state_o;

  jtag_tap_ctrl #(.IR_LEN(5), .IR_RESET(5'h01)) dut (
    .tck_i        (tck),
    .ntrst_i      (ntrst),
    .tms_i        (tms),
    .tdi_i        (tdi),
    .tdo_o        (tdo_o),
    .tdo_en_o     (tdo_en_o),
    .dr_tdo_i     (dr_tdo),
    .capture_dr_o (capture_dr_o),
    .shift_dr_o   (shift_dr_o),
    .update_dr_o  (update_dr_o),
    .ir_o         (ir_o),
    .tlr_o        (tlr_o),
    .state_o      (state_o)
  );

  initial forever #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model states: 0 TLR, 1 RTI, DR branch 2..8, IR branch 9..15, both ordered
  // Select, Capture, Shift, Exit1, Pause, Exit2, Update.
  localparam int M_TLR = 0, M_RTI = 1, M_DR = 2, M_IR = 9;
  localparam int O_SEL = 0, O_CAP = 1, O_SH = 2, O_EX1 = 3, O_PAUSE = 4, O_EX2 = 5, O_UPD = 6;

  int         m_s;
  logic [4:0] m_ir;
  logic [4:0] m_sh;
  logic       m_tdo;
  logic       m_en;
  logic       last_tdo;
  int         n_cap;
  int         n_upd;

  function automatic int nxt(input int s, input logic t);
    int b;
    int o;
    if (s == M_TLR) return t ? M_TLR : M_RTI;
    if (s == M_RTI) return t ? M_DR : M_RTI;
    b = (s >= M_IR) ? M_IR : M_DR;
    o = s - b;
    case (o)
      O_SEL:   return t ? ((b == M_DR) ? M_IR : M_TLR) : b + O_CAP;
      O_CAP:   return t ? b + O_EX1 : b + O_SH;
      O_SH:    return t ? b + O_EX1 : b + O_SH;
      O_EX1:   return t ? b + O_UPD : b + O_PAUSE;
      O_PAUSE: return t ? b + O_EX2 : b + O_PAUSE;
      O_EX2:   return t ? b + O_UPD : b + O_SH;
      default: return t ? M_DR : M_RTI;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s   = M_TLR;
    m_ir  = 5'h01;
    m_sh  = 5'h00;
    m_tdo = 1'b0;
    m_en  = 1'b0;
  endtask

  task automatic step(input logic t, input logic d, input logic r);
    tms    = t;
    tdi    = d;
    dr_tdo = r;
    @(posedge tck);
    if (m_s == M_TLR)          m_ir = 5'h01;
    if (m_s == M_IR + O_CAP)   m_sh = 5'b00001;
    if (m_s == M_IR + O_SH)    m_sh = {d, m_sh[4:1]};
    if (m_s == M_IR + O_UPD)   m_ir = m_sh;
    m_s = nxt(m_s, t);
    #1;
    check("capture_dr", 32'(capture_dr_o), 32'(m_s == M_DR + O_CAP));
    check("shift_dr",   32'(shift_dr_o),   32'(m_s == M_DR + O_SH));
    check("update_dr",  32'(update_dr_o),  32'(m_s == M_DR + O_UPD));
    check("tlr",        32'(tlr_o),        32'(m_s == M_TLR));
    check("state_tlr",  32'(state_o == 4'hF), 32'(m_s == M_TLR));
    check("ir",         32'(ir_o),         32'(m_ir));
    n_cap += int'(capture_dr_o);
    n_upd += int'(update_dr_o);
    @(negedge tck);
    m_en  = (m_s == M_IR + O_SH) || (m_s == M_DR + O_SH);
    m_tdo = (m_s == M_IR + O_SH) ? m_sh[0] : ((m_s == M_DR + O_SH) ? r : 1'b0);
    #1;
    check("tdo",    32'(tdo_o),    32'(m_tdo));
    check("tdo_en", 32'(tdo_en_o), 32'(m_en));
    last_tdo = tdo_o;
  endtask

  logic [4:0]  ir_word;
  logic [4:0]  ir_val;
  logic [31:0] dr_word;
  logic [31:0] idc;
  logic        pause_hi;

  initial begin
    ntrst  = 1'b0;
    tms    = 1'b1;
    tdi    = 1'b0;
    dr_tdo = 1'b0;
    n_cap  = 0;
    n_upd  = 0;
    model_reset();

    #12;
    check("rst_state",  32'(state_o),  32'h0000000F);
    check("rst_tlr",    32'(tlr_o),    32'h1);
    check("rst_ir",     32'(ir_o),     32'h01);
    check("rst_tdo",    32'(tdo_o),    32'h0);
    check("rst_tdo_en", 32'(tdo_en_o), 32'h0);
    #1 ntrst = 1'b1;

    // TLR -> RTI
    step(1'b0, 1'b0, 1'b0);
    check("rti_tlr_low", 32'(tlr_o),    32'h0);
    check("rti_ir",      32'(ir_o),     32'h01);
    check("rti_tdo_en",  32'(tdo_en_o), 32'h0);

    // IR scan of DTMCS, reading back the captured 01 pattern
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ir_word    = '0;
    ir_word[0] = last_tdo;
    ir_val     = 5'h10;
    for (int i = 0; i < 5; i++) begin
      step(i == 4, ir_val[i], 1'b0);
      if (i < 4) ir_word[i+1] = last_tdo;
    end
    check("ir_tdo_seq", 32'(ir_word), 32'h01);
    step(1'b1, 1'b0, 1'b0);
    check("ir_latency", 32'(ir_o), 32'h01);
    step(1'b0, 1'b0, 1'b0);
    check("ir_dtmcs", 32'(ir_o), 32'h10);

    // From Shift-DR, five TMS=1 reach TLR; IR returns to IDCODE
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("in_shift_dr", 32'(shift_dr_o), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("five_tms_tlr", 32'(tlr_o), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("tlr_ir_reset", 32'(ir_o), 32'h01);

    // DR scan of a 32-bit IDCODE
    idc = 32'h1DEAD3FF;
    step(1'b0, 1'b0, 1'b0);
    n_cap = 0;
    n_upd = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, idc[0]);
    dr_word    = '0;
    dr_word[0] = last_tdo;
    for (int k = 1; k < 32; k++) begin
      step(1'b0, 1'b0, idc[k]);
      dr_word[k] = last_tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    check("ex1_shift_drop", 32'(shift_dr_o), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("dr_idcode",  dr_word,      32'h1DEAD3FF);
    check("cap_pulses", 32'(n_cap),   32'h1);
    check("upd_pulses", 32'(n_upd),   32'h1);

    // Shift-DR -> Pause-DR x3 -> Exit2 -> Shift-DR -> Update
    n_upd = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    pause_hi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      pause_hi = pause_hi | shift_dr_o | tdo_en_o;
    end
    check("pause_quiet", 32'(pause_hi), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("resume_shift", 32'(shift_dr_o), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pause_upd_once", 32'(n_upd), 32'h1);

    // Load DMI, then reset in the middle of another IR shift
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ir_val = 5'h11;
    for (int i = 0; i < 5; i++) step(i == 4, ir_val[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ir_dmi", 32'(ir_o), 32'h11);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    #1 ntrst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_state",  32'(state_o),  32'h0000000F);
    check("mid_rst_ir",     32'(ir_o),     32'h01);
    check("mid_rst_tdo",    32'(tdo_o),    32'h0);
    check("mid_rst_tdo_en", 32'(tdo_en_o), 32'h0);
    #1 ntrst = 1'b1;

    // Random walk against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
